// File: rtl/axil_reg_slave.sv
// axil_reg_slave
//   AXI4-Lite slave exposing NUM_REGS x AXI_DATA_WIDTH control/status registers.
//   AW and W are captured independently into one-deep holding registers and a
//   write commits once both are present. One outstanding write and one
//   outstanding read at a time. Accesses inside the bus but outside the
//   register window, and writes to read-only registers, return SLVERR.
//
// Ports
//   aclk, aresetn          clock, asynchronous active-low reset
//   s_axil_aw*/w*/b*       write address / data / response channels
//   s_axil_ar*/r*          read address / data channels
//   reg_out                RW register contents, reg i at slice i (RO slices 0)
//   reg_in                 hardware values returned for RO registers
//   wr_pulse / rd_pulse    one-cycle strobe per register on write commit / AR accept
module axil_reg_slave #(
    parameter int unsigned                AXI_ADDR_WIDTH = 32,
    parameter int unsigned                AXI_DATA_WIDTH = 32,
    parameter int unsigned                NUM_REGS       = 16,
    parameter logic [AXI_ADDR_WIDTH-1:0]  BASE_ADDR      = '0,
    parameter logic [NUM_REGS-1:0]        RO_MASK        = '0
) (
    input  logic                               aclk,
    input  logic                               aresetn,
    input  logic [AXI_ADDR_WIDTH-1:0]          s_axil_awaddr,
    input  logic                               s_axil_awvalid,
    output logic                               s_axil_awready,
    input  logic [AXI_DATA_WIDTH-1:0]          s_axil_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]        s_axil_wstrb,
    input  logic                               s_axil_wvalid,
    output logic                               s_axil_wready,
    output logic [1:0]                         s_axil_bresp,
    output logic                               s_axil_bvalid,
    input  logic                               s_axil_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]          s_axil_araddr,
    input  logic                               s_axil_arvalid,
    output logic                               s_axil_arready,
    output logic [AXI_DATA_WIDTH-1:0]          s_axil_rdata,
    output logic [1:0]                         s_axil_rresp,
    output logic                               s_axil_rvalid,
    input  logic                               s_axil_rready,
    output logic [NUM_REGS*AXI_DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*AXI_DATA_WIDTH-1:0] reg_in,
    output logic [NUM_REGS-1:0]                wr_pulse,
    output logic [NUM_REGS-1:0]                rd_pulse
);

    localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
    localparam int unsigned LSB    = $clog2(STRB_W);
    localparam int unsigned IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [AXI_ADDR_WIDTH-1:0] NREGS_A = AXI_ADDR_WIDTH'(NUM_REGS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Write path state
    logic                      r_aw_full;
    logic [AXI_ADDR_WIDTH-1:0] r_aw_addr;
    logic                      r_w_full;
    logic [AXI_DATA_WIDTH-1:0] r_w_data;
    logic [STRB_W-1:0]         r_w_strb;
    logic                      r_bvalid;
    logic [1:0]                r_bresp;
    logic [NUM_REGS-1:0]       r_wr_pulse;
    logic [AXI_DATA_WIDTH-1:0] r_regs [NUM_REGS];

    // Read path state
    logic                      r_rvalid;
    logic [1:0]                r_rresp;
    logic [AXI_DATA_WIDTH-1:0] r_rdata;
    logic [NUM_REGS-1:0]       r_rd_pulse;

    // Keeps all readies low during reset and for the edge that releases it.
    logic                      r_live;

    logic                      w_awready, w_wready, w_arready, w_commit;
    logic [AXI_ADDR_WIDTH-1:0] w_aw_word, w_ar_word;
    logic [IDX_W-1:0]          w_aw_idx, w_ar_idx;
    logic                      w_aw_hit, w_ar_hit, w_aw_wr_ok;
    logic [AXI_DATA_WIDTH-1:0] w_rd_src [NUM_REGS];

    assign w_awready = r_live && !r_aw_full && !r_bvalid;
    assign w_wready  = r_live && !r_w_full  && !r_bvalid;
    assign w_arready = r_live && !r_rvalid;
    assign w_commit  = r_aw_full && r_w_full;

    // Window decode; the subtraction wraps for addresses below BASE_ADDR, so
    // the explicit >= test is what rejects them.
    always_comb begin
        w_aw_word  = (r_aw_addr - BASE_ADDR) >> LSB;
        w_aw_hit   = (r_aw_addr >= BASE_ADDR) && (w_aw_word < NREGS_A);
        w_aw_idx   = w_aw_word[IDX_W-1:0];
        w_aw_wr_ok = w_aw_hit && !RO_MASK[w_aw_idx];
        w_ar_word  = (s_axil_araddr - BASE_ADDR) >> LSB;
        w_ar_hit   = (s_axil_araddr >= BASE_ADDR) && (w_ar_word < NREGS_A);
        w_ar_idx   = w_ar_word[IDX_W-1:0];
    end

    always_comb begin
        reg_out = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            w_rd_src[i] = RO_MASK[i] ? reg_in[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] : r_regs[i];
            if (!RO_MASK[i]) begin
                reg_out[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = r_regs[i];
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
        end
    end

    // Readies are zero whenever a holding register is full, so capture and
    // commit never coincide on the same edge.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_aw_full  <= 1'b0;
            r_aw_addr  <= '0;
            r_w_full   <= 1'b0;
            r_w_data   <= '0;
            r_w_strb   <= '0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
            r_wr_pulse <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_wr_pulse <= '0;
            if (s_axil_awvalid && w_awready) begin
                r_aw_full <= 1'b1;
                r_aw_addr <= s_axil_awaddr;
            end
            if (s_axil_wvalid && w_wready) begin
                r_w_full <= 1'b1;
                r_w_data <= s_axil_wdata;
                r_w_strb <= s_axil_wstrb;
            end
            if (r_bvalid && s_axil_bready) begin
                r_bvalid <= 1'b0;
            end
            if (w_commit) begin
                r_aw_full <= 1'b0;
                r_w_full  <= 1'b0;
                r_bvalid  <= 1'b1;
                if (w_aw_wr_ok) begin
                    for (int unsigned k = 0; k < STRB_W; k++) begin
                        if (r_w_strb[k]) begin
                            r_regs[w_aw_idx][k*8 +: 8] <= r_w_data[k*8 +: 8];
                        end
                    end
                    r_wr_pulse[w_aw_idx] <= 1'b1;
                    r_bresp              <= RESP_OKAY;
                end else begin
                    r_bresp <= RESP_SLVERR;
                end
            end
        end
    end

    // Read data is captured from the pre-edge register values, so a read
    // accepted on a commit edge returns the old contents.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rvalid   <= 1'b0;
            r_rresp    <= RESP_OKAY;
            r_rdata    <= '0;
            r_rd_pulse <= '0;
        end else begin
            r_rd_pulse <= '0;
            if (r_rvalid && s_axil_rready) begin
                r_rvalid <= 1'b0;
            end
            if (s_axil_arvalid && w_arready) begin
                r_rvalid <= 1'b1;
                if (w_ar_hit) begin
                    r_rdata              <= w_rd_src[w_ar_idx];
                    r_rresp              <= RESP_OKAY;
                    r_rd_pulse[w_ar_idx] <= 1'b1;
                end else begin
                    r_rdata <= '0;
                    r_rresp <= RESP_SLVERR;
                end
            end
        end
    end

    assign s_axil_awready = w_awready;
    assign s_axil_wready  = w_wready;
    assign s_axil_arready = w_arready;
    assign s_axil_bvalid  = r_bvalid;
    assign s_axil_bresp   = r_bresp;
    assign s_axil_rvalid  = r_rvalid;
    assign s_axil_rresp   = r_rresp;
    assign s_axil_rdata   = r_rdata;
    assign wr_pulse       = r_wr_pulse;
    assign rd_pulse       = r_rd_pulse;

endmodule

// File: tb/tb_axil_reg_slave.sv
// tb_axil_reg_slave
//   Scoreboard bench for axil_reg_slave: 16 registers, window at 0x4000_0000,
//   register 3 read-only. Expected B/R responses are queued when a request is
//   driven and compared by channel monitors when the handshake occurs.
module tb_axil_reg_slave;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic [31:0]  s_axil_awaddr, s_axil_wdata, s_axil_araddr, s_axil_rdata;
    logic [3:0]   s_axil_wstrb;
    logic         s_axil_awvalid, s_axil_awready, s_axil_wvalid, s_axil_wready;
    logic [1:0]   s_axil_bresp, s_axil_rresp;
    logic         s_axil_bvalid, s_axil_bready, s_axil_arvalid, s_axil_arready;
    logic         s_axil_rvalid, s_axil_rready;
    logic [511:0] reg_out, reg_in;
    logic [15:0]  wr_pulse, rd_pulse;

    int unsigned  n_tests = 0;
    int unsigned  n_fail  = 0;
    logic [1:0]   b_q [$];
    logic [33:0]  r_q [$];
    logic [31:0]  m_regs [16];

    axil_reg_slave #(
        .AXI_ADDR_WIDTH (32),
        .AXI_DATA_WIDTH (32),
        .NUM_REGS       (16),
        .BASE_ADDR      (BASE),
        .RO_MASK        (16'h0008)
    ) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .s_axil_awaddr  (s_axil_awaddr),
        .s_axil_awvalid (s_axil_awvalid),
        .s_axil_awready (s_axil_awready),
        .s_axil_wdata   (s_axil_wdata),
        .s_axil_wstrb   (s_axil_wstrb),
        .s_axil_wvalid  (s_axil_wvalid),
        .s_axil_wready  (s_axil_wready),
        .s_axil_bresp   (s_axil_bresp),
        .s_axil_bvalid  (s_axil_bvalid),
        .s_axil_bready  (s_axil_bready),
        .s_axil_araddr  (s_axil_araddr),
        .s_axil_arvalid (s_axil_arvalid),
        .s_axil_arready (s_axil_arready),
        .s_axil_rdata   (s_axil_rdata),
        .s_axil_rresp   (s_axil_rresp),
        .s_axil_rvalid  (s_axil_rvalid),
        .s_axil_rready  (s_axil_rready),
        .reg_out        (reg_out),
        .reg_in         (reg_in),
        .wr_pulse       (wr_pulse),
        .rd_pulse       (rd_pulse)
    );

    always #5 aclk = ~aclk;

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit m_hit(input logic [31:0] a);
        return (a >= BASE) && ((a - BASE) < 32'd64);
    endfunction

    function automatic int unsigned m_idx(input logic [31:0] a);
        logic [31:0] o;
        int unsigned r;
        o = a - BASE;
        r = {28'd0, o[5:2]};
        return r;
    endfunction

    function automatic logic [511:0] model_vec();
        logic [511:0] v;
        v = '0;
        for (int i = 0; i < 16; i++) begin
            if (i != 3) v[i*32 +: 32] = m_regs[i];
        end
        return v;
    endfunction

    // Channel monitors: compare at the negedge preceding each handshake edge.
    always @(negedge aclk) begin
        if (aresetn && s_axil_bvalid && s_axil_bready) begin
            if (b_q.size() == 0) check_eq("b_unexpected", 512'(1), 512'(0));
            else check_eq("bresp", 512'(s_axil_bresp), 512'(b_q.pop_front()));
        end
        if (aresetn && s_axil_rvalid && s_axil_rready) begin
            if (r_q.size() == 0) check_eq("r_unexpected", 512'(1), 512'(0));
            else check_eq("rdata_rresp", 512'({s_axil_rdata, s_axil_rresp}), 512'(r_q.pop_front()));
        end
    end

    // Called and returns at #1 after an edge; returns just after the accept edge(s).
    task automatic drive(input bit do_aw, input bit do_w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        bit aw_p, w_p;
        int unsigned n;
        aw_p = do_aw; w_p = do_w; n = 0;
        s_axil_awaddr = a; s_axil_wdata = d; s_axil_wstrb = s;
        s_axil_awvalid = aw_p; s_axil_wvalid = w_p;
        while ((aw_p || w_p) && n < 20) begin
            if (s_axil_awvalid && s_axil_awready) aw_p = 1'b0;
            if (s_axil_wvalid && s_axil_wready) w_p = 1'b0;
            @(posedge aclk); #1;
            s_axil_awvalid = aw_p; s_axil_wvalid = w_p;
            n++;
        end
        if (aw_p || w_p) check_eq("drive_timeout", 512'(1), 512'(0));
    endtask

    task automatic wait_b();
        int unsigned n;
        n = 0;
        while (s_axil_bvalid && n < 20) begin @(posedge aclk); #1; n++; end
        if (s_axil_bvalid) check_eq("b_timeout", 512'(1), 512'(0));
    endtask

    task automatic wait_r();
        int unsigned n;
        n = 0;
        while (s_axil_rvalid && n < 20) begin @(posedge aclk); #1; n++; end
        if (s_axil_rvalid) check_eq("r_timeout", 512'(1), 512'(0));
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int unsigned idx;
        logic [15:0] p;
        idx = m_idx(a); p = '0;
        if (m_hit(a) && idx != 3) begin
            for (int k = 0; k < 4; k++) if (s[k]) m_regs[idx][k*8 +: 8] = d[k*8 +: 8];
            p[idx] = 1'b1;
            b_q.push_back(2'b00);
        end else begin
            b_q.push_back(2'b10);
        end
        drive(1'b1, 1'b1, a, d, s);
        check_eq("b_early", 512'(s_axil_bvalid), 512'(0));
        @(posedge aclk); #1;
        check_eq("b_valid", 512'(s_axil_bvalid), 512'(1));
        check_eq("wr_pulse", 512'(wr_pulse), 512'(p));
        check_eq("reg_out", reg_out, model_vec());
        wait_b();
        check_eq("wr_pulse_off", 512'(wr_pulse), 512'(0));
    endtask

    task automatic rd(input logic [31:0] a);
        int unsigned idx, n;
        logic [15:0] p;
        logic [31:0] e;
        bit acc;
        idx = m_idx(a); p = '0; e = '0; n = 0; acc = 1'b0;
        if (m_hit(a)) begin
            e = (idx == 3) ? 32'h1234_5678 : m_regs[idx];
            p[idx] = 1'b1;
            r_q.push_back({e, 2'b00});
        end else begin
            r_q.push_back({32'h0, 2'b10});
        end
        s_axil_araddr = a; s_axil_arvalid = 1'b1;
        while (!acc && n < 20) begin
            if (s_axil_arready) acc = 1'b1;
            @(posedge aclk); #1;
            n++;
        end
        s_axil_arvalid = 1'b0;
        if (!acc) check_eq("ar_timeout", 512'(1), 512'(0));
        check_eq("r_valid", 512'(s_axil_rvalid), 512'(1));
        check_eq("rd_pulse", 512'(rd_pulse), 512'(p));
        wait_r();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pat;
        for (int i = 0; i < 16; i++) begin
            m_regs[i] = '0;
            reg_in[i*32 +: 32] = 32'hA5A5_0000 | 32'(i);
        end
        reg_in[3*32 +: 32] = 32'h1234_5678;
        aresetn = 1'b0;
        s_axil_awaddr = '0; s_axil_wdata = '0; s_axil_wstrb = '0; s_axil_araddr = '0;
        s_axil_awvalid = 1'b1; s_axil_arvalid = 1'b1; s_axil_wvalid = 1'b0;
        s_axil_bready = 1'b1; s_axil_rready = 1'b1;

        // Reset with requests pending
        repeat (3) @(posedge aclk);
        #1;
        check_eq("rst_readies", 512'({s_axil_awready, s_axil_wready, s_axil_arready}), 512'(0));
        check_eq("rst_valids", 512'({s_axil_bvalid, s_axil_rvalid}), 512'(0));
        check_eq("rst_resp_data", 512'({s_axil_bresp, s_axil_rresp, s_axil_rdata}), 512'(0));
        check_eq("rst_pulses", 512'({wr_pulse, rd_pulse}), 512'(0));
        check_eq("rst_reg_out", reg_out, 512'(0));
        s_axil_awvalid = 1'b0; s_axil_arvalid = 1'b0;
        aresetn = 1'b1;
        @(posedge aclk); #1;
        check_eq("rel_readies", 512'({s_axil_awready, s_axil_wready, s_axil_arready}), 512'(3'b111));

        // Byte-strobed write and readback
        wr(BASE + 32'h8, 32'hDEAD_BEEF, 4'b0101);
        check_eq("reg2_val", 512'(reg_out[2*32 +: 32]), 512'(32'h00AD_00EF));
        rd(BASE + 32'h8);

        // Zero strobe: OKAY and pulse, no byte change
        wr(BASE + 32'h8, 32'hFFFF_FFFF, 4'b0000);
        rd(BASE + 32'h8);

        // Several registers incl. first/last, low address bits ignored
        for (int i = 0; i < 16; i += 5) begin
            pat = 32'h1111_1111 * 32'(i + 1) ^ 32'hC3C3_0F0F;
            wr(BASE + 32'(i * 4) + 32'(i % 4), pat, 4'hF);
        end
        for (int i = 0; i < 16; i += 5) rd(BASE + 32'(i * 4));

        // Out-of-window accesses
        wr(BASE + 32'd64, 32'h5555_AAAA, 4'hF);
        rd(BASE + 32'd64);
        wr(BASE - 32'd4, 32'h5555_AAAA, 4'hF);
        rd(BASE - 32'd4);

        // Read-only register
        wr(BASE + 32'hC, 32'hFFFF_FFFF, 4'hF);
        rd(BASE + 32'hC);

        // W leads AW by 3 cycles, B held off for 5 cycles
        m_regs[5] = 32'h55AA_1234;
        b_q.push_back(2'b00);
        s_axil_bready = 1'b0;
        s_axil_wdata = 32'h55AA_1234; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
        @(posedge aclk); #1;
        s_axil_wvalid = 1'b0;
        check_eq("st_wready", 512'(s_axil_wready), 512'(0));
        check_eq("st_awready", 512'(s_axil_awready), 512'(1));
        repeat (2) begin
            @(posedge aclk); #1;
            check_eq("st_no_b", 512'({s_axil_bvalid, s_axil_wready}), 512'(0));
        end
        s_axil_awaddr = BASE + 32'd20; s_axil_awvalid = 1'b1;
        @(posedge aclk); #1;
        s_axil_awvalid = 1'b0;
        check_eq("st_no_b2", 512'(s_axil_bvalid), 512'(0));
        @(posedge aclk); #1;
        check_eq("st_reg_out", reg_out, model_vec());
        for (int i = 0; i < 5; i++) begin
            check_eq("st_hold", 512'({s_axil_bvalid, s_axil_bresp, s_axil_awready, s_axil_wready}),
                     512'(5'b1_00_00));
            check_eq("st_wr_pulse", 512'(wr_pulse), 512'((i == 0) ? 16'h0020 : 16'h0000));
            @(posedge aclk); #1;
        end
        s_axil_bready = 1'b1;
        @(posedge aclk); #1;
        check_eq("st_release", 512'({s_axil_bvalid, s_axil_awready, s_axil_wready}), 512'(3'b011));

        // Read accepted on the same edge as a write commit to that register
        wr(BASE + 32'h4, 32'h1, 4'hF);
        b_q.push_back(2'b00);
        s_axil_awaddr = BASE + 32'h4; s_axil_wdata = 32'h2; s_axil_wstrb = 4'hF;
        s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
        @(posedge aclk); #1;
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        r_q.push_back({32'h1, 2'b00});
        s_axil_araddr = BASE + 32'h4; s_axil_arvalid = 1'b1;
        @(posedge aclk); #1;
        s_axil_arvalid = 1'b0;
        m_regs[1] = 32'h2;
        check_eq("se_pulses", 512'({wr_pulse, rd_pulse}), 512'({16'h0002, 16'h0002}));
        check_eq("se_valids", 512'({s_axil_bvalid, s_axil_rvalid}), 512'(2'b11));
        @(posedge aclk); #1;
        check_eq("se_done", 512'({s_axil_bvalid, s_axil_rvalid}), 512'(0));
        rd(BASE + 32'h4);

        // Reset with a lone AW pending: it must be dropped
        s_axil_awaddr = BASE + 32'd24; s_axil_awvalid = 1'b1;
        @(posedge aclk); #1;
        s_axil_awvalid = 1'b0;
        check_eq("mr_aw_held", 512'(s_axil_awready), 512'(0));
        #2 aresetn = 1'b0;
        #3 aresetn = 1'b1;
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        check_eq("mr_reg_out", reg_out, 512'(0));
        @(posedge aclk); #1;
        check_eq("mr_awready", 512'(s_axil_awready), 512'(1));
        drive(1'b0, 1'b1, 32'h0, 32'hCAFE_F00D, 4'hF);
        repeat (3) begin
            @(posedge aclk); #1;
            check_eq("mr_no_b", 512'(s_axil_bvalid), 512'(0));
        end
        m_regs[6] = 32'hCAFE_F00D;
        b_q.push_back(2'b00);
        drive(1'b1, 1'b0, BASE + 32'd24, 32'hCAFE_F00D, 4'hF);
        @(posedge aclk); #1;
        check_eq("mr_wr_pulse", 512'(wr_pulse), 512'(16'h0040));
        check_eq("mr_reg_out2", reg_out, model_vec());
        wait_b();
        rd(BASE + 32'd24);

        repeat (2) @(posedge aclk);
        #1;
        check_eq("b_q_empty", 512'(b_q.size()), 512'(0));
        check_eq("r_q_empty", 512'(r_q.size()), 512'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axil_reg_slave.md
# axil_reg_slave

AXI4-Lite slave endpoint that terminates one slave port of the AXI-Lite interconnect and exposes a bank of 32-bit control/status registers to user logic. Accepts AW and W independently, commits byte-strobed writes, returns B and R responses with full valid/ready handshaking, and flags decode errors inside its window with SLVERR. This is the responder that sits behind each `m_axil[i]` port of the interconnect.

## Interface
- AXI_ADDR_WIDTH, 32, address width (matches axil_pkg)
- AXI_DATA_WIDTH, 32, data width; byte lanes = AXI_DATA_WIDTH/8
- NUM_REGS, 16, number of word registers (1..256)
- BASE_ADDR, 32'h0000_0000, window base; aligned to NUM_REGS*bytes-per-word
- RO_MASK, '0 (NUM_REGS bits), bit i = 1: register i is read-only, sourced from reg_in
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- s_axil_awaddr/awvalid/awready  in/in/out  AXI_ADDR_WIDTH/1/1  write address channel
- s_axil_wdata/wstrb/wvalid/wready  in/in/in/out  AXI_DATA_WIDTH/AXI_DATA_WIDTH/8/1/1  write data channel
- s_axil_bresp/bvalid/bready  out/out/in  2/1/1  write response channel
- s_axil_araddr/arvalid/arready  in/in/out  AXI_ADDR_WIDTH/1/1  read address channel
- s_axil_rdata/rresp/rvalid/rready  out/out/out/in  AXI_DATA_WIDTH/2/1/1  read data channel
- reg_out  out  NUM_REGS*AXI_DATA_WIDTH  RW register contents, reg i at slice i (RO slices drive 0)
- reg_in  in  NUM_REGS*AXI_DATA_WIDTH  hardware values for RO registers
- wr_pulse  out  NUM_REGS  one-cycle pulse when register i is written
- rd_pulse  out  NUM_REGS  one-cycle pulse when register i is read (AR accepted)

## Operation
- Decode: offset = addr − BASE_ADDR; idx = offset >> log2(bytes/word); low byte-offset bits ignored. Hit iff addr ≥ BASE_ADDR and idx < NUM_REGS.
- Write path: AW holding register (aw_full) and W holding register (w_full) fill independently. awready = !aw_full && !bvalid; wready = !w_full && !bvalid.
- Commit when aw_full && w_full: hit and RW → bytes with wstrb[k]=1 updated, wr_pulse[idx]=1, bresp=OKAY (2'b00); miss or RO → no update, no pulse, bresp=SLVERR (2'b10). Same edge sets bvalid, clears aw_full/w_full.
- bvalid, bresp held stable until bready; bvalid clears on the bvalid&&bready edge. No new AW/W accepted while bvalid=1 (one outstanding write).
- wstrb = 0 on a hit: OKAY, no byte changes, wr_pulse still asserted.
- Read path: arready = !rvalid. On AR handshake: rdata = hit ? (RO ? reg_in slice : stored reg) : 0; rresp = hit ? OKAY : SLVERR; rd_pulse[idx]=1 on hit; rvalid set. rdata/rresp held until rready; one outstanding read.
- Read and write paths fully independent; an AR accepted on the same edge as a write commit to the same register returns the pre-write value.

## Timing
- Reset (aresetn=0, asynchronous): awready=wready=arready=0 while asserted; bvalid=rvalid=0, bresp=rresp=0, rdata=0, all stored registers 0, wr_pulse=rd_pulse=0, aw_full=w_full=0. Ready outputs rise the first cycle after deassertion.
- AW and W accepted at edge T → commit at edge T+1 → bvalid high after T+1. W at T, AW at T+3 → bvalid after T+4.
- reg_out reflects a write the cycle after commit (same cycle as bvalid).
- AR accepted at edge T → rvalid high after T; rready=1 at edge T+1 → rvalid low, arready high after T+1. Sustained throughput: one read per 2 cycles, one write per 3 cycles.
- wr_pulse/rd_pulse high exactly one cycle, coincident with bvalid/rvalid first cycle.
- Reset mid-transaction drops all pending state; no response issued for it.

## Test plan
- Reset: hold aresetn=0 with awvalid/arvalid=1 → all readies 0, bvalid=rvalid=0, reg_out all 0; release → awready=wready=arready=1 next cycle.
- Write 0xDEADBEEF to BASE+0x8 with wstrb=4'b0101, AW and W same cycle → bresp=OKAY 2 cycles later, wr_pulse[2] one cycle, reg 2 = 0x00AD00EF; readback rdata=0x00AD00EF, rresp=OKAY, rd_pulse[2].
- W leads AW by 3 cycles with bready=0 for 5 cycles → wready drops after W, bvalid held stable 5 cycles, awready/wready stay 0 until B handshake.
- Address BASE+NUM_REGS*4 write and read → bresp=SLVERR, rresp=SLVERR, rdata=0, no reg change, no pulses.
- RO_MASK bit 3 set, reg_in slice 3 = 0x12345678: write reg 3 → SLVERR, no change; read reg 3 → 0x12345678, OKAY.
- Read reg 1 accepted same edge as write commit to reg 1 (old 0x1, new 0x2) → rdata=0x1; following read → 0x2.
